// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and angle wrap helper for the CORDIC angle generator.
package cordic_pkg;

   localparam logic [31:0] DEG_90     = 32'h005A_0000;
   localparam logic [31:0] DEG_180    = 32'h00B4_0000;
   localparam logic [31:0] DEG_270    = 32'h010E_0000;
   localparam logic [31:0] DEG_360    = 32'h0168_0000;
   localparam int          CORDIC_LAT = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } gen_state_t;

   // Operands are always below 720 deg, so one conditional subtract is enough.
   function automatic logic [31:0] wrap360(input logic [31:0] x);
      logic [31:0] y;
      if (x >= DEG_360) begin
         y = x - DEG_360;
      end else begin
         y = x;
      end
      return y;
   endfunction

endpackage

// File: rtl/cordic_vld_dly.sv
// LAT-deep issue-flag delay line that tracks samples travelling through the CORDIC pipeline.
module cordic_vld_dly #(
   parameter int LAT = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [LAT-1:0] r_sr;

   // Shift register; reset flushes in-flight flags so stale results are never reported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else begin
         r_sr[0] <= din;
         for (int i = 1; i < LAT; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign dout = r_sr[LAT-1];

endmodule

// File: rtl/cordic_angle_gen.sv
// Angle-sweep sequencer feeding a pipelined CORDIC; tracks result validity and sample index.
// Optional build macro CORDIC_GEN_CONT_EN adds i_stop and continuous (count==0) sweeps.
module cordic_angle_gen
   import cordic_pkg::*;
#(
   parameter int LAT   = CORDIC_LAT,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [31:0]      i_phase0,
   input  logic [31:0]      i_step,
   input  logic [CNT_W-1:0] i_count,
`ifdef CORDIC_GEN_CONT_EN
   input  logic             i_stop,
`endif
   output logic [31:0]      o_angle,
   output logic             o_en,
   output logic             o_busy,
   output logic             o_res_valid,
   output logic [CNT_W-1:0] o_res_idx,
   output logic             o_done
);

   localparam int PW = $clog2(LAT + 2);

   gen_state_t       r_state, w_state_nxt;
   logic [31:0]      r_angle, w_angle_nxt;
   logic [31:0]      r_step, w_step_nxt;
   logic [CNT_W-1:0] r_left, w_left_nxt;
   logic [CNT_W-1:0] r_idx, w_idx_nxt;
   logic [PW-1:0]    r_pend, w_pend_nxt;
   logic             r_cont, w_cont_nxt;
   logic             r_en, r_busy, r_done;
   logic             w_en_nxt, w_busy_nxt, w_done_nxt;
   logic             w_issue, w_vld, w_stop, w_cont_ok;

`ifdef CORDIC_GEN_CONT_EN
   assign w_stop    = i_stop;
   assign w_cont_ok = 1'b1;
`else
   assign w_stop    = 1'b0;
   assign w_cont_ok = 1'b0;
`endif

   // Every RUN cycle presents exactly one new sample on o_angle.
   assign w_issue = (r_state == RUN);

   cordic_vld_dly #(.LAT(LAT)) u_vld_dly (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (w_issue),
      .dout  (w_vld)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_angle_nxt = r_angle;
      w_step_nxt  = r_step;
      w_left_nxt  = r_left;
      w_cont_nxt  = r_cont;
      w_idx_nxt   = w_vld ? (r_idx + CNT_W'(1'b1)) : r_idx;

      case ({w_issue, w_vld})
         2'b10:   w_pend_nxt = r_pend + PW'(1'b1);
         2'b01:   w_pend_nxt = r_pend - PW'(1'b1);
         default: w_pend_nxt = r_pend;
      endcase

      case (r_state)
         IDLE: begin
            if (i_start) begin
               if ((i_count != '0) || w_cont_ok) begin
                  w_state_nxt = RUN;
                  w_angle_nxt = wrap360(i_phase0);
                  w_step_nxt  = wrap360(i_step);
                  w_left_nxt  = i_count;
                  w_cont_nxt  = (i_count == '0);
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = DONE;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_stop || (!r_cont && (r_left == CNT_W'(1'b1)))) begin
               w_state_nxt = FLUSH;
            end else begin
               w_angle_nxt = wrap360(r_angle + r_step);
               w_left_nxt  = r_left - CNT_W'(1'b1);
            end
         end
         FLUSH: begin
            // Only drained results remain; the last one leaves exactly one flag pending.
            if (w_vld && (r_pend == PW'(1'b1))) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = FLUSH;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_en_nxt   = (w_state_nxt == RUN) || (w_state_nxt == FLUSH);
      w_busy_nxt = (w_state_nxt != IDLE);
      w_done_nxt = (w_state_nxt == DONE);
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_angle <= 32'h0000_0000;
         r_step  <= 32'h0000_0000;
         r_left  <= '0;
         r_idx   <= '0;
         r_pend  <= '0;
         r_cont  <= 1'b0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_angle <= w_angle_nxt;
         r_step  <= w_step_nxt;
         r_left  <= w_left_nxt;
         r_idx   <= w_idx_nxt;
         r_pend  <= w_pend_nxt;
         r_cont  <= w_cont_nxt;
         r_en    <= w_en_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign o_angle     = r_angle;
   assign o_en        = r_en;
   assign o_busy      = r_busy;
   assign o_res_valid = w_vld;
   assign o_res_idx   = r_idx;
   assign o_done      = r_done;

endmodule

// File: tb/tb_cordic_angle_gen.sv
// Scoreboard bench for cordic_angle_gen: directed sweeps, wrap, zero count, ignored start, reset.
module tb_cordic_angle_gen;

   localparam int LAT_TB = 12;

   logic        clk;
   logic        i_rst_n;
   logic        i_start;
   logic [31:0] i_phase0;
   logic [31:0] i_step;
   logic [15:0] i_count;
`ifdef CORDIC_GEN_CONT_EN
   logic        i_stop;
`endif
   logic [31:0] o_angle;
   logic        o_en;
   logic        o_busy;
   logic        o_res_valid;
   logic [15:0] o_res_idx;
   logic        o_done;

   cordic_angle_gen #(.LAT(LAT_TB), .CNT_W(16)) dut (
      .i_clk       (clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_phase0    (i_phase0),
      .i_step      (i_step),
      .i_count     (i_count),
`ifdef CORDIC_GEN_CONT_EN
      .i_stop      (i_stop),
`endif
      .o_angle     (o_angle),
      .o_en        (o_en),
      .o_busy      (o_busy),
      .o_res_valid (o_res_valid),
      .o_res_idx   (o_res_idx),
      .o_done      (o_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_ang_q[$];
   int          exp_idx_q[$];
   logic [31:0] vec[$];
   logic [31:0] hist[0:LAT_TB];
   int          res_cnt = 0;
   int          done_cnt = 0;
   int          unexp = 0;
   int          en_glitch = 0;
   int          cyc = 0;
   int          last_vld_cyc = -1;
   logic        prev_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every result and checks index and the angle issued LAT cycles earlier.
   always @(negedge clk) begin
      cyc++;
      for (int i = LAT_TB; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = o_angle;
      if (o_res_valid) begin
         res_cnt++;
         last_vld_cyc = cyc;
         if (exp_ang_q.size() == 0) begin
            unexp++;
         end else begin
            check("res_idx", 64'(o_res_idx), 64'(exp_idx_q.pop_front()));
            check("res_angle_lat", 64'(hist[LAT_TB]), 64'(exp_ang_q.pop_front()));
         end
      end
      if (o_done) begin
         done_cnt++;
         if (last_vld_cyc >= 0) check("done_after_last_vld", 64'(cyc - last_vld_cyc), 64'd1);
         last_vld_cyc = -1;
      end
      if (prev_en && !o_en && !o_done && i_rst_n) en_glitch++;
      prev_en = o_en;
   end

   task automatic wait_done(input string nm, input int d0);
      int c;
      c = 0;
      while (done_cnt == d0 && c < 300) begin
         @(posedge clk);
         c++;
      end
      #1;
      repeat (3) @(posedge clk);
      #1;
      check({nm, "_done_once"}, 64'(done_cnt - d0), 64'd1);
   endtask

   // Issues one sweep and checks the per-cycle angle stream; vec holds the hand-computed angles.
   task automatic sweep(input string nm, input logic [31:0] ph, input logic [31:0] st,
                        input logic [15:0] cnt, input int n, input bit poke, input bit use_stop);
      int d0, r0, g0;
      d0 = done_cnt;
      r0 = res_cnt;
      g0 = en_glitch;
      @(posedge clk); #1;
      i_start = 1'b1; i_phase0 = ph; i_step = st; i_count = cnt;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < n; k++) begin
         check({nm, "_angle"}, 64'(o_angle), 64'(vec[k]));
         check({nm, "_en_run"}, 64'(o_en), 64'd1);
         exp_ang_q.push_back(vec[k]);
         exp_idx_q.push_back(k);
         if (poke && k == 1) begin
            i_start = 1'b1; i_count = 16'd2; i_phase0 = 32'h00B4_0000;
         end else begin
            i_start = 1'b0;
         end
`ifdef CORDIC_GEN_CONT_EN
         i_stop = (use_stop && k == n - 1);
`endif
         @(posedge clk); #1;
      end
      i_start = 1'b0;
`ifdef CORDIC_GEN_CONT_EN
      i_stop = 1'b0;
`endif
      check({nm, "_hold_flush"}, 64'(o_angle), 64'(vec[n-1]));
      check({nm, "_en_flush"}, 64'(o_en), 64'd1);
      wait_done(nm, d0);
      check({nm, "_en_after"}, 64'(o_en), 64'd0);
      check({nm, "_busy_after"}, 64'(o_busy), 64'd0);
      check({nm, "_hold_idle"}, 64'(o_angle), 64'(vec[n-1]));
      check({nm, "_res_count"}, 64'(res_cnt - r0), 64'(n));
      check({nm, "_sb_empty"}, 64'(exp_ang_q.size()), 64'd0);
      check({nm, "_en_continuous"}, 64'(en_glitch - g0), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int d0, r0, en_hi;
      i_rst_n = 1'b0; i_start = 1'b0; i_phase0 = 32'h0; i_step = 32'h0; i_count = 16'h0;
`ifdef CORDIC_GEN_CONT_EN
      i_stop = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_angle", 64'(o_angle), 64'd0);
      check("rst_en", 64'(o_en), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_valid", 64'(o_res_valid), 64'd0);
      check("rst_idx", 64'(o_res_idx), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      i_rst_n = 1'b1;

      vec = '{32'h0000_0000, 32'h001E_0000, 32'h003C_0000, 32'h005A_0000};
      sweep("basic", 32'h0000_0000, 32'h001E_0000, 16'd4, 4, 1'b0, 1'b0);

      vec = '{32'h0159_0000, 32'h000F_0000, 32'h002D_0000};
      sweep("wrap", 32'h0159_0000, 32'h001E_0000, 16'd3, 3, 1'b0, 1'b0);

      vec = '{32'h0000_0000, 32'h005A_0000};
      sweep("ph360", 32'h0168_0000, 32'h005A_0000, 16'd2, 2, 1'b0, 1'b0);

      vec = '{32'h0000_0000, 32'h001E_0000, 32'h003C_0000};
      sweep("step390", 32'h0000_0000, 32'h0186_0000, 16'd3, 3, 1'b0, 1'b0);

      vec = '{32'h0010_0000, 32'h0020_0000, 32'h0030_0000, 32'h0040_0000, 32'h0050_0000};
      sweep("poke", 32'h0010_0000, 32'h0010_0000, 16'd5, 5, 1'b1, 1'b0);

`ifdef CORDIC_GEN_CONT_EN
      vec = {};
      for (int k = 0; k < 100; k++) vec.push_back(32'(k) << 16);
      sweep("cont", 32'h0000_0000, 32'h0001_0000, 16'd0, 100, 1'b0, 1'b1);
`else
      d0 = done_cnt;
      r0 = res_cnt;
      en_hi = 0;
      @(posedge clk); #1;
      i_start = 1'b1; i_phase0 = 32'h0; i_step = 32'h001E_0000; i_count = 16'd0;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("zero_done_pulse", 64'(o_done), 64'd1);
      for (int c = 0; c < 20; c++) begin
         if (o_en) en_hi++;
         @(posedge clk); #1;
      end
      check("zero_done_once", 64'(done_cnt - d0), 64'd1);
      check("zero_en_never", 64'(en_hi), 64'd0);
      check("zero_no_results", 64'(res_cnt - r0), 64'd0);
`endif

      // Reset in the middle of a sweep: outputs clear at once, no stale results later.
      r0 = res_cnt;
      @(posedge clk); #1;
      i_start = 1'b1; i_phase0 = 32'h0; i_step = 32'h001E_0000; i_count = 16'd10;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy", 64'(o_busy), 64'd1);
      i_rst_n = 1'b0;
      #1;
      check("mrst_angle", 64'(o_angle), 64'd0);
      check("mrst_en", 64'(o_en), 64'd0);
      check("mrst_busy", 64'(o_busy), 64'd0);
      check("mrst_valid", 64'(o_res_valid), 64'd0);
      check("mrst_idx", 64'(o_res_idx), 64'd0);
      check("mrst_done", 64'(o_done), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      check("mrst_no_results", 64'(res_cnt - r0), 64'd0);
      check("mrst_idle", 64'(o_busy), 64'd0);

      check("no_spurious_valid", 64'(unexp), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
